// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg : shared mode encoding and default sizing for the pipelined adder
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG_W = 4;

endpackage

`default_nettype wire

// File: rtl/cla_segment.sv
// ----------------------------------------------------------------------------
// cla_segment : combinational carry-lookahead adder slice of SEG_W bits
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cla_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             c_in,
  output logic [SEG_W-1:0] s,
  output logic             c_out
);

  logic [SEG_W-1:0] gen;
  logic [SEG_W-1:0] prop;
  logic [SEG_W:0]   carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Each carry is a flat sum-of-products of generate/propagate terms.
  always_comb begin
    logic term;
    logic acc;
    carry    = '0;
    carry[0] = c_in;
    term     = 1'b0;
    acc      = 1'b0;
    for (int i = 0; i < SEG_W; i++) begin
      acc = c_in;
      for (int m = 0; m <= i; m++) acc = acc & prop[m];
      for (int j = 0; j <= i; j++) begin
        term = gen[j];
        for (int m = j + 1; m <= i; m++) term = term & prop[m];
        acc = acc | term;
      end
      carry[i+1] = acc;
    end
  end

  assign s     = prop ^ carry[SEG_W-1:0];
  assign c_out = carry[SEG_W];

endmodule

`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
// ----------------------------------------------------------------------------
// pipelined_cla_adder : segmented CLA add/sub, one segment resolved per stage
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG = (WIDTH + SEG_W - 1) / SEG_W;

  logic                       adv;
  logic [WIDTH-1:0]           b_eff;
  logic                       c_first;
  logic [NSEG-1:0]            valid_q, valid_d;
  logic [NSEG-1:0]            c_q, c_d;
  logic [NSEG-1:0][WIDTH-1:0] a_q, a_d;
  logic [NSEG-1:0][WIDTH-1:0] b_q, b_d;
  logic [NSEG-1:0][WIDTH-1:0] s_q, s_d;
  logic                       ovf_q, ovf_d;
  logic                       zero_q, zero_d;
  logic                       unused_bits;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign b_eff   = (mode == MODE_SUB) ? ~B : B;
  assign c_first = (mode == MODE_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO = k * SEG_W;
    localparam int SW = (k == NSEG - 1) ? (WIDTH - LO) : SEG_W;
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SW{1'b1}}) << LO;

    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             c_in, v_in;
    logic [SW-1:0]    seg_s;
    logic             seg_c;

    if (k == 0) begin : g_head
      assign a_in = A;
      assign b_in = b_eff;
      assign s_in = '0;
      assign c_in = c_first;
      assign v_in = in_valid;
    end else begin : g_body
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign s_in = s_q[k-1];
      assign c_in = c_q[k-1];
      assign v_in = valid_q[k-1];
    end

    cla_segment #(.SEG_W(SW)) u_seg (
      .a     (a_in[LO +: SW]),
      .b     (b_in[LO +: SW]),
      .c_in  (c_in),
      .s     (seg_s),
      .c_out (seg_c)
    );

    assign a_d[k]     = a_in;
    assign b_d[k]     = b_in;
    assign s_d[k]     = (s_in & ~MASK) | (WIDTH'(seg_s) << LO);
    assign c_d[k]     = seg_c;
    assign valid_d[k] = v_in;
  end

  assign ovf_d  = (a_d[NSEG-1][WIDTH-1] == b_d[NSEG-1][WIDTH-1]) &&
                  (s_d[NSEG-1][WIDTH-1] != a_d[NSEG-1][WIDTH-1]);
  assign zero_d = (s_d[NSEG-1] == '0);

  // Bubbles load zeros so the output word reads 0 whenever out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      c_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv) begin
      valid_q <= valid_d;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= valid_d[k] ? a_d[k] : '0;
        b_q[k] <= valid_d[k] ? b_d[k] : '0;
        s_q[k] <= valid_d[k] ? s_d[k] : '0;
        c_q[k] <= valid_d[k] & c_d[k];
      end
      ovf_q  <= valid_d[NSEG-1] & ovf_d;
      zero_q <= valid_d[NSEG-1] & zero_d;
    end
  end

  // Resolved low operand bits are carried only to keep the stage word uniform.
  assign unused_bits = ^{a_q, b_q};

  assign out_valid = valid_q[NSEG-1];
  assign R         = s_q[NSEG-1];
  assign cout      = c_q[NSEG-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire
